// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and state encoding for the multiply-accumulate stage
package mul_pkg;
   localparam int N_DEF     = 8;
   localparam int M_DEF     = 8;
   localparam int ACC_W_DEF = 24;
   localparam int CNT_W_DEF = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   typedef enum logic [1:0] {S_IDLE = ST_IDLE, S_ACC = ST_ACC, S_HOLD = ST_HOLD} state_t;
endpackage

// File: rtl/mul_acc_stage_if.sv
// mul_acc_stage_if: product input, control and result handshake bundle
interface mul_acc_stage_if
   import mul_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int M     = M_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             start;
   logic [CNT_W-1:0] len;
   logic [N+M-1:0]   prod;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   modport master (output start, len, prod, in_valid, out_ready,
                   input  in_ready, acc_out, ovf, out_valid, busy);
   modport slave  (input  start, len, prod, in_valid, out_ready,
                   output in_ready, acc_out, ovf, out_valid, busy);
endinterface

// File: rtl/mul_acc_stage.sv
// mul_acc_stage: accumulates len products into a registered sum with sticky overflow
module mul_acc_stage
   import mul_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int M     = M_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic            clk,
   input logic            rst_n,
   mul_acc_stage_if.slave bus
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic [ACC_W-1:0] acc, acc_nx;
   logic             ovf_r, ovf_nx;
   logic [ACC_W:0]   sum;

   // One extra bit catches the carry out of the accumulator
   assign sum = {1'b0, acc} + {{(ACC_W+1-N-M){1'b0}}, bus.prod};

   assign bus.in_ready  = state == S_ACC;
   assign bus.out_valid = state == S_HOLD;
   assign bus.busy      = state != S_IDLE;
   assign bus.acc_out   = acc;
   assign bus.ovf       = ovf_r;

   // State and datapath registers; reset discards any partial result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         count <= '0;
         acc   <= '0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         acc   <= acc_nx;
         ovf_r <= ovf_nx;
      end
   end

   // Next-state: start only in IDLE, beats only in ACC, drain on out_ready in HOLD
   always_comb begin
      state_nx = state;
      count_nx = count;
      acc_nx   = acc;
      ovf_nx   = ovf_r;
      case (state)
         S_IDLE: if (bus.start) begin
            acc_nx   = '0;
            ovf_nx   = 1'b0;
            count_nx = bus.len;
            state_nx = (bus.len == '0) ? S_HOLD : S_ACC;
         end
         S_ACC: if (bus.in_valid) begin
            acc_nx   = sum[ACC_W-1:0];
            ovf_nx   = ovf_r | sum[ACC_W];
            count_nx = count - 1'b1;
            state_nx = (count == CNT_W'(1)) ? S_HOLD : S_ACC;
         end
         S_HOLD: state_nx = bus.out_ready ? S_IDLE : S_HOLD;
         default: state_nx = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_mul_acc_stage.sv
// tb_mul_acc_stage: directed table, corner sequences and random runs on 24- and 20-bit accumulators
module tb_mul_acc_stage;
   logic clk, rst_n;
   logic start, in_valid, out_ready;
   logic [7:0] len;
   logic [15:0] prod;
   int checks = 0;
   int errors = 0;
   logic [15:0] pq[$];

   mul_acc_stage_if #(.ACC_W(24)) ifa ();
   mul_acc_stage_if #(.ACC_W(20)) ifb ();

   assign ifa.start = start;     assign ifb.start = start;
   assign ifa.len = len;         assign ifb.len = len;
   assign ifa.prod = prod;       assign ifb.prod = prod;
   assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;
   assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

   mul_acc_stage #(.ACC_W(24)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   mul_acc_stage #(.ACC_W(20)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {
      int          l;
      int          p0;
      int          step;
      int          gap;
      logic [23:0] e24;
      logic        o24;
      logic [19:0] e20;
      logic        o20;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s *ERROR* got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one accumulation of the products queued in pq and checks both instances
   task automatic run(input string tag, input int gap, input logic [23:0] e24, input logic o24,
                      input logic [19:0] e20, input logic o20);
      int l;
      l = pq.size();
      start = 1; len = 8'(l);
      tick();
      start = 0;
      chk({tag, " in_ready after start"}, 32'(ifa.in_ready), (l > 0) ? 1 : 0);
      for (int k = 0; k < l; k++) begin
         in_valid = 1; prod = pq[k];
         tick();
         in_valid = 0; prod = 16'hFFFF;
         if (k < l - 1) repeat (gap) tick();
      end
      chk({tag, " out_valid a"}, 32'(ifa.out_valid), 1);
      chk({tag, " out_valid b"}, 32'(ifb.out_valid), 1);
      chk({tag, " acc a"}, 32'(ifa.acc_out), 32'(e24));
      chk({tag, " ovf a"}, 32'(ifa.ovf), 32'(o24));
      chk({tag, " acc b"}, 32'(ifb.acc_out), 32'(e20));
      chk({tag, " ovf b"}, 32'(ifb.ovf), 32'(o20));
      out_ready = 1;
      tick();
      out_ready = 0;
      chk({tag, " out_valid drop"}, 32'(ifa.out_valid), 0);
      chk({tag, " busy drop"}, 32'(ifa.busy), 0);
      chk({tag, " acc kept"}, 32'(ifa.acc_out), 32'(e24));
   endtask

   vec_t vt[8];

   initial begin
      longint unsigned s;
      int l;
      logic [7:0] a, b;
      vt[0] = '{3, 65025, 0, 0, 24'd195075, 1'b0, 20'd195075, 1'b0};
      vt[1] = '{17, 65025, 0, 0, 24'd1105425, 1'b0, 20'd56849, 1'b1};
      vt[2] = '{0, 0, 0, 0, 24'd0, 1'b0, 20'd0, 1'b0};
      vt[3] = '{1, 7, 0, 0, 24'd7, 1'b0, 20'd7, 1'b0};
      vt[4] = '{4, 1, 1, 3, 24'd10, 1'b0, 20'd10, 1'b0};
      vt[5] = '{5, 100, 100, 1, 24'd1500, 1'b0, 20'd1500, 1'b0};
      vt[6] = '{2, 65535, 0, 2, 24'd131070, 1'b0, 20'd131070, 1'b0};
      vt[7] = '{255, 65025, 0, 0, 24'd16581375, 1'b0, 20'd852735, 1'b1};
      rst_n = 0; start = 0; len = 0; prod = 0; in_valid = 0; out_ready = 0;
      tick(); tick();
      rst_n = 1;
      chk("reset acc", 32'(ifa.acc_out), 0);
      chk("reset ovf", 32'(ifa.ovf), 0);
      chk("reset out_valid", 32'(ifa.out_valid), 0);
      chk("reset in_ready", 32'(ifa.in_ready), 0);
      chk("reset busy", 32'(ifa.busy), 0);

      foreach (vt[i]) begin
         pq.delete();
         for (int k = 0; k < vt[i].l; k++) pq.push_back(16'(vt[i].p0 + k * vt[i].step));
         run($sformatf("vec%0d", i), vt[i].gap, vt[i].e24, vt[i].o24, vt[i].e20, vt[i].o20);
      end

      // Gaps with stray start pulses in ACC, then a long HOLD with more noise
      start = 1; len = 4;
      tick();
      start = 0;
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1; prod = 16'(k);
         tick();
         in_valid = 0; prod = 16'hFFFF;
         if (k < 4) begin
            start = 1; len = 9;
            repeat (3) tick();
            start = 0;
            chk("gap in_ready", 32'(ifa.in_ready), 1);
            chk("gap out_valid", 32'(ifa.out_valid), 0);
         end
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold out_valid", 32'(ifa.out_valid), 1);
         chk("hold acc", 32'(ifa.acc_out), 10);
         start = 1; len = 3; in_valid = 1; prod = 16'd999;
         tick();
      end
      start = 0; in_valid = 0;
      chk("hold acc end", 32'(ifa.acc_out), 10);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("release out_valid", 32'(ifa.out_valid), 0);
      chk("release busy", 32'(ifa.busy), 0);
      tick();
      chk("no queued start", 32'(ifa.busy), 0);
      chk("acc after release", 32'(ifa.acc_out), 10);

      // Reset in the middle of an accumulation
      start = 1; len = 5;
      tick();
      start = 0;
      repeat (2) begin
         in_valid = 1; prod = 16'd5;
         tick();
      end
      in_valid = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("midrst acc", 32'(ifa.acc_out), 0);
      chk("midrst ovf", 32'(ifb.ovf), 0);
      chk("midrst out_valid", 32'(ifa.out_valid), 0);
      chk("midrst in_ready", 32'(ifa.in_ready), 0);
      chk("midrst busy", 32'(ifa.busy), 0);
      pq.delete(); pq.push_back(16'd7);
      run("after reset", 0, 24'd7, 1'b0, 20'd7, 1'b0);

      // Random operand pairs through a behavioural multiplier
      for (int r = 0; r < 50; r++) begin
         l = $urandom_range(1, 20);
         s = 0;
         pq.delete();
         for (int k = 0; k < l; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            pq.push_back(16'(a) * 16'(b));
            s += longint'(a) * longint'(b);
         end
         run($sformatf("rand%0d", r), $urandom_range(0, 2), s[23:0], s >= 64'd16777216,
             s[19:0], s >= 64'd1048576);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
